// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/return controller for the pipelined 32x32 multiplier.
// Requests are issued straight into a fixed-latency datapath (LAT cycles, no
// stall). A valid/tag shift pipe follows each op to the datapath output, where
// the product is captured into an in-order response FIFO. Credits
// (occupancy + in-flight < DEPTH) guarantee every capture finds a free slot.
// Optional feature: define MUL_FLUSH_EN to add the synchronous 'flush' port.
module mul_issue_ctrl #(
    parameter int LAT   = 3,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             mul_clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_signed,
    input  logic [31:0]      req_x,
    input  logic [31:0]      req_y,
    input  logic [TAG_W-1:0] req_tag,
    output logic             dp_valid,
    output logic             dp_signed,
    output logic [31:0]      dp_x,
    output logic [31:0]      dp_y,
    input  logic [63:0]      dp_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
`ifdef MUL_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int INF_W = $clog2(LAT + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CRD_W = $clog2(DEPTH + LAT + 1);

    logic             flush_i;
    logic [LAT-1:0]   pv_q;
    logic [TAG_W-1:0] tag_q   [LAT];
    logic [63:0]      res_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic [INF_W-1:0] inflight_q;
    logic             credit_ok;
    logic             fire;
    logic             push;
    logic             pop;

`ifdef MUL_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits come only from registered counters, so req_ready never depends
    // on rsp_ready; it is also held low while reset is asserted.
    assign credit_ok = (CRD_W'(occ_q) + CRD_W'(inflight_q)) < CRD_W'(DEPTH);
    assign req_ready = resetn & ~flush_i & credit_ok;
    assign fire      = req_valid & req_ready;
    assign push      = pv_q[LAT-1];
    assign rsp_valid = (occ_q != '0);
    assign pop       = rsp_valid & rsp_ready & ~flush_i;
    assign busy      = (inflight_q != '0) | rsp_valid;

    assign dp_valid  = fire;
    assign dp_signed = req_signed;
    assign dp_x      = req_x;
    assign dp_y      = req_y;

    // The head entry lives in a register array, so these outputs hold steady
    // until the entry is popped.
    assign rsp_result = res_mem[rd_ptr_q];
    assign rsp_tag    = tag_mem[rd_ptr_q];

    // Valid shift pipe that marks which datapath cycles carry a live op.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbour, giving a true shift.
    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            pv_q <= '0;
        end else if (flush_i) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= fire;
            for (int i = 1; i < LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
            end
        end
    end

    // Tag shift pipe running alongside the valid bits.
    // NOTE: data-only storage has no reset; the valid bits and occupancy
    // already say which entries mean anything.
    always_ff @(posedge mul_clk) begin
        tag_q[0] <= req_tag;
        for (int i = 1; i < LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    // In-flight counter mirroring popcount(pv_q).
    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            inflight_q <= '0;
        end else if (flush_i) begin
            inflight_q <= '0;
        end else if (fire && !push) begin
            inflight_q <= inflight_q + 1'b1;
        end else if (!fire && push) begin
            inflight_q <= inflight_q - 1'b1;
        end
    end

    // Response FIFO storage: capture the product as the op leaves the datapath.
    always_ff @(posedge mul_clk) begin
        if (push && !flush_i) begin
            res_mem[wr_ptr_q] <= dp_result;
            tag_mem[wr_ptr_q] <= tag_q[LAT-1];
        end
    end

    // Response FIFO pointers and occupancy; push+pop together leaves occ as is.
    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                occ_q <= occ_q + 1'b1;
            end else if (pop && !push) begin
                occ_q <= occ_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: the bench plays the fixed-latency datapath and
// keeps a transaction-level reference (queue of in-flight ops, queue of
// responses) that predicts every output each cycle.
module tb_mul_issue_ctrl;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             mul_clk = 1'b0;
    logic             resetn;
    logic             req_valid;
    logic             req_ready;
    logic             req_signed;
    logic [31:0]      req_x;
    logic [31:0]      req_y;
    logic [TAG_W-1:0] req_tag;
    logic             dp_valid;
    logic             dp_signed;
    logic [31:0]      dp_x;
    logic [31:0]      dp_y;
    logic [63:0]      dp_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    logic             flush_s = 1'b0;

    mul_issue_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .mul_clk    (mul_clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_signed (req_signed),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_tag    (req_tag),
        .dp_valid   (dp_valid),
        .dp_signed  (dp_signed),
        .dp_x       (dp_x),
        .dp_y       (dp_y),
        .dp_result  (dp_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
`ifdef MUL_FLUSH_EN
        ,
        .flush      (flush_s)
`endif
    );

    always #5 mul_clk = ~mul_clk;

    typedef struct {
        longint unsigned  c;
        logic [63:0]      prod;
        logic [TAG_W-1:0] tag;
    } op_t;

    op_t             pend_q[$];
    op_t             fifo_q[$];
    longint unsigned cur = 0;
    int              n_checks = 0;
    int              n_errors = 0;

    logic             obs_dp_valid;
    logic             obs_rsp_valid;
    logic             obs_req_ready;
    logic [63:0]      obs_rsp_result;
    logic [TAG_W-1:0] obs_rsp_tag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cur);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x, input logic [31:0] y);
        longint a;
        longint b;
        if (s) begin
            a = longint'($signed(x));
            b = longint'($signed(y));
        end else begin
            a = longint'({32'b0, x});
            b = longint'({32'b0, y});
        end
        return 64'(a * b);
    endfunction

    // One clock cycle: present datapath output, check outputs, advance model.
    task automatic cycle();
        logic exp_ready;
        logic fire_m;
        logic pop_m;
        bool_capture: begin end
        if (pend_q.size() > 0 && pend_q[0].c + LAT == cur)
            dp_result = pend_q[0].prod;
        else
            dp_result = {$urandom(), $urandom()};
        #1;
        exp_ready = resetn && !flush_s && ((pend_q.size() + fifo_q.size()) < DEPTH);
        fire_m    = req_valid && exp_ready;
        pop_m     = rsp_ready && (fifo_q.size() != 0) && !flush_s;
        check("req_ready", req_ready, exp_ready);
        check("dp_valid", dp_valid, fire_m);
        check("dp_signed", dp_signed, req_signed);
        check("dp_x", dp_x, req_x);
        check("dp_y", dp_y, req_y);
        check("rsp_valid", rsp_valid, fifo_q.size() != 0);
        if (fifo_q.size() != 0) begin
            check("rsp_result", rsp_result, fifo_q[0].prod);
            check("rsp_tag", rsp_tag, fifo_q[0].tag);
        end
        check("busy", busy, (pend_q.size() + fifo_q.size()) != 0);
        check("push_into_full", dut.pv_q[LAT-1] && (dut.occ_q == DEPTH) && !pop_m, 1'b0);
        obs_dp_valid   = dp_valid;
        obs_rsp_valid  = rsp_valid;
        obs_req_ready  = req_ready;
        obs_rsp_result = rsp_result;
        obs_rsp_tag    = rsp_tag;
        @(posedge mul_clk);
        if (!resetn || flush_s) begin
            pend_q.delete();
            fifo_q.delete();
        end else begin
            if (pop_m) void'(fifo_q.pop_front());
            if (pend_q.size() > 0 && pend_q[0].c + LAT == cur)
                fifo_q.push_back(pend_q.pop_front());
            if (fire_m) begin
                op_t op;
                op.c    = cur;
                op.prod = ref_mul(req_signed, req_x, req_y);
                op.tag  = req_tag;
                pend_q.push_back(op);
            end
        end
        cur++;
        @(negedge mul_clk);
    endtask

    task automatic drain();
        int n;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while ((pend_q.size() + fifo_q.size()) != 0 && n < 50) begin
            cycle();
            n++;
        end
        cycle();
    endtask

    task automatic run_single(input logic s, input logic [31:0] x, input logic [31:0] y,
                              input logic [TAG_W-1:0] t, input logic [63:0] exp, input string nm);
        int n;
        drain();
        req_signed = s;
        req_x      = x;
        req_y      = y;
        req_tag    = t;
        req_valid  = 1'b1;
        rsp_ready  = 1'b1;
        cycle();
        check({nm, "_issue"}, obs_dp_valid, 1'b1);
        req_valid = 1'b0;
        n = 0;
        obs_rsp_valid = 1'b0;
        while (!obs_rsp_valid && n < 20) begin
            cycle();
            n++;
        end
        check({nm, "_latency"}, n, LAT + 1);
        check({nm, "_result"}, obs_rsp_result, exp);
        check({nm, "_tag"}, obs_rsp_tag, t);
    endtask

    task automatic in_flight_three();
        drain();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_tag = TAG_W'(i);
            req_x   = $urandom();
            req_y   = $urandom();
            cycle();
        end
    endtask

    task automatic idle_no_rsp(input string nm);
        int nrsp;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        nrsp = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            cycle();
            if (obs_rsp_valid) nrsp++;
        end
        check({nm, "_no_rsp"}, nrsp, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf;
        int k;
        resetn     = 1'b0;
        req_valid  = 1'b1;
        req_signed = 1'b0;
        req_x      = '0;
        req_y      = '0;
        req_tag    = '0;
        rsp_ready  = 1'b0;
        dp_result  = '0;
        #2;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_dp_valid", dp_valid, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        req_valid = 1'b0;
        @(negedge mul_clk);
        resetn = 1'b1;

        // Directed products and minimum latency.
        run_single(1'b1, 32'hFFFF_FFFD, 32'd7, 4'd5, 64'hFFFF_FFFF_FFFF_FFEB, "t1_neg3x7");
        run_single(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9, 64'hFFFF_FFFE_0000_0001, "t2_unsigned_max");
        run_single(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 64'h0000_0000_0000_0001, "t2_signed_m1");

        // Credit exhaustion with a stalled consumer, then in-order drain.
        drain();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        nf = 0;
        for (int i = 0; i < 8; i++) begin
            req_tag    = TAG_W'(nf);
            req_signed = 1'($urandom());
            req_x      = $urandom();
            req_y      = $urandom();
            cycle();
            if (obs_dp_valid) nf++;
        end
        check("t3_fires", nf, DEPTH);
        check("t3_ready_low", obs_req_ready, 1'b0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (i == 0) check("t3_ready_before_pop", obs_req_ready, 1'b0);
            if (i == 1) check("t3_ready_after_pop", obs_req_ready, 1'b1);
            if (obs_rsp_valid) begin
                check("t3_order", obs_rsp_tag, k);
                k++;
            end
        end
        check("t3_count", k, DEPTH);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 10000; i++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            rsp_ready  = (i < 3000) ? 1'b1 : ($urandom_range(0, 2) != 0);
            req_signed = 1'($urandom());
            req_x      = $urandom();
            req_y      = $urandom();
            req_tag    = TAG_W'($urandom());
`ifdef MUL_FLUSH_EN
            flush_s    = ($urandom_range(0, 199) == 0);
`endif
            cycle();
        end
        flush_s = 1'b0;

        // Reset with three ops in flight.
        in_flight_three();
        check("t5_busy_before", busy, 1'b1);
        resetn = 1'b0;
        #1;
        check("t5_busy", busy, 1'b0);
        check("t5_rsp_valid", rsp_valid, 1'b0);
        check("t5_req_ready", req_ready, 1'b0);
        check("t5_dp_valid", dp_valid, 1'b0);
        pend_q.delete();
        fifo_q.delete();
        @(posedge mul_clk);
        @(negedge mul_clk);
        resetn = 1'b1;
        idle_no_rsp("t5");

`ifdef MUL_FLUSH_EN
        // Flush with three ops in flight.
        in_flight_three();
        flush_s = 1'b1;
        cycle();
        check("tf_ready_in_flush", obs_req_ready, 1'b0);
        flush_s = 1'b0;
        #1;
        check("tf_busy", busy, 1'b0);
        check("tf_ready_back", req_ready, 1'b1);
        idle_no_rsp("tf");
`endif

        drain();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
